// File: rtl/fib_stream_pkg.sv
// Shared primitives for the Fibonacci stream block: FSM encodings and boolean constants.
`default_nettype none

package fib_stream_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] FIB_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] FIB_CALC = 2'd1;
  localparam logic [STATE_W-1:0] FIB_EMIT = 2'd2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage : fib_stream_pkg

`default_nettype wire

// File: rtl/fib_stream_sat_add.sv
// Unsigned N-bit adder with carry-out flag; SAT=1 clamps the sum to all-ones on carry.
`default_nettype none

module sat_add #(
  parameter int N   = 16,
  parameter int SAT = 1
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o,
  output logic         ovf_o
);

  logic [N:0] full_w;

  assign full_w = {1'b0, a_i} + {1'b0, b_i};
  assign ovf_o  = full_w[N];

  if (SAT != 0) begin : g_sat
    assign sum_o = full_w[N] ? {N{1'b1}} : full_w[N-1:0];
  end else begin : g_wrap
    assign sum_o = full_w[N-1:0];
  end

endmodule : sat_add

`default_nettype wire

// File: rtl/fib_stream.sv
// Returns Fibonacci F(n) (or every term F(0)..F(n) when STREAM=1) over valid/ready channels.
`default_nettype none

module fib_stream
  import fib_stream_pkg::*;
#(
  parameter int N      = 16,
  parameter int STREAM = 0,
  parameter int SAT    = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in0,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out0,
  output logic         out_ovf,
  output logic         out_last
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [N-1:0]       cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               bovf_q, bovf_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [N-1:0]       out0_q, out0_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_last_q, out_last_d;
  logic               step_w;
  logic [N-1:0]       sum_w;
  logic               carry_w;

  sat_add #(
    .N   (N),
    .SAT (SAT)
  ) u_sat_add (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (sum_w),
    .ovf_o (carry_w)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bovf_d     = bovf_q;
    out0_d     = out0_q;
    out_ovf_d  = out_ovf_q;
    out_last_d = out_last_q;
    step_w     = FALSE;

    case (state_q)
      FIB_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = '0;
          b_d     = {{(N-1){1'b0}}, 1'b1};
          cnt_d   = in0;
          ovf_d   = FALSE;
          bovf_d  = FALSE;
          state_d = FIB_CALC;
        end
      end
      FIB_CALC: begin
        if (STREAM != 0) begin
          out0_d     = a_q;
          out_ovf_d  = ovf_q;
          out_last_d = (cnt_q == '0);
          state_d    = FIB_EMIT;
        end else if (cnt_q == '0) begin
          out0_d     = a_q;
          out_ovf_d  = ovf_q;
          out_last_d = TRUE;
          state_d    = FIB_EMIT;
        end else begin
          step_w = TRUE;
        end
      end
      FIB_EMIT: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d = FIB_IDLE;
          end else begin
            step_w  = TRUE;
            state_d = FIB_CALC;
          end
        end
      end
      default: state_d = FIB_IDLE;
    endcase

    // b runs one term ahead of a, so its overflow only reaches the reported flag one step later.
    if (step_w) begin
      a_d    = b_q;
      b_d    = sum_w;
      cnt_d  = cnt_q - 1'b1;
      ovf_d  = bovf_q;
      bovf_d = bovf_q | carry_w;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= FIB_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      bovf_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out0_q      <= '0;
      out_ovf_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      bovf_q      <= bovf_d;
      in_ready_q  <= (state_d == FIB_IDLE);
      out_valid_q <= (state_d == FIB_EMIT);
      out0_q      <= out0_d;
      out_ovf_q   <= out_ovf_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out0      = out0_q;
  assign out_ovf   = out_ovf_q;
  assign out_last  = out_last_q;

endmodule : fib_stream

`default_nettype wire

// File: tb/tb_fib_stream.sv
// Directed bench: single-result saturating and wrapping instances plus a streaming instance.
`default_nettype none

module tb_fib_stream;

  logic             clk;
  logic             nrst;
  logic [2:0]       iv;
  logic [2:0]       ir;
  logic [2:0][15:0] din;
  logic [2:0]       ov;
  logic [2:0]       ordy;
  logic [2:0][15:0] dout;
  logic [2:0]       oovf;
  logic [2:0]       olast;

  int checks   = 0;
  int failures = 0;

  fib_stream #(.N(16), .STREAM(0), .SAT(1)) u_sat (
    .clk(clk), .nrst(nrst), .in_valid(iv[0]), .in_ready(ir[0]), .in0(din[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out0(dout[0]), .out_ovf(oovf[0]), .out_last(olast[0])
  );

  fib_stream #(.N(16), .STREAM(0), .SAT(0)) u_wrap (
    .clk(clk), .nrst(nrst), .in_valid(iv[1]), .in_ready(ir[1]), .in0(din[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out0(dout[1]), .out_ovf(oovf[1]), .out_last(olast[1])
  );

  fib_stream #(.N(16), .STREAM(1), .SAT(1)) u_strm (
    .clk(clk), .nrst(nrst), .in_valid(iv[2]), .in_ready(ir[2]), .in0(din[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out0(dout[2]), .out_ovf(oovf[2]), .out_last(olast[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int sel);
    int g = 0;
    while (!ir[sel] && g < 100) begin
      tick();
      g++;
    end
    chk("in_ready_wait", {31'd0, ir[sel]}, 32'd1);
  endtask

  // Accept n on a single-result instance, measure latency, then retire the beat.
  task automatic run0(input int sel, input string tag, input logic [15:0] n,
                      input logic [15:0] exp, input logic exp_ovf);
    int lat = 0;
    wait_ready(sel);
    din[sel] = n;
    iv[sel]  = 1'b1;
    tick();
    iv[sel]  = 1'b0;
    while (!ov[sel] && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, n + 32'd1);
    chk({tag, "_val"}, {16'd0, dout[sel]}, {16'd0, exp});
    chk({tag, "_ovf"}, {31'd0, oovf[sel]}, {31'd0, exp_ovf});
    chk({tag, "_last"}, {31'd0, olast[sel]}, 32'd1);
    tick();
    chk({tag, "_hold"}, {15'd0, ov[sel], dout[sel]}, {15'd1, exp});
    chk({tag, "_busy"}, {31'd0, ir[sel]}, 32'd0);
    ordy[sel] = 1'b1;
    tick();
    ordy[sel] = 1'b0;
    chk({tag, "_retire"}, {31'd0, ov[sel]}, 32'd0);
  endtask

  initial begin
    logic [15:0] exp_beats [6];
    logic [15:0] held;
    int g;

    exp_beats[0] = 16'd0; exp_beats[1] = 16'd1; exp_beats[2] = 16'd1;
    exp_beats[3] = 16'd2; exp_beats[4] = 16'd3; exp_beats[5] = 16'd5;

    nrst = 1'b0;
    iv   = '0;
    din  = '0;
    ordy = 3'b100;
    repeat (3) tick();
    chk("rst_valid", {29'd0, ov}, 32'd0);
    chk("rst_ready", {29'd0, ir}, 32'd0);
    chk("rst_out0", {16'd0, dout[0]}, 32'd0);
    chk("rst_flags", {26'd0, oovf, olast}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    chk("rel_ready", {29'd0, ir}, 32'd7);

    run0(0, "n10", 16'd10, 16'd55, 1'b0);
    run0(0, "n0", 16'd0, 16'd0, 1'b0);
    run0(0, "n1", 16'd1, 16'd1, 1'b0);
    run0(0, "n2", 16'd2, 16'd1, 1'b0);
    run0(0, "n24", 16'd24, 16'd46368, 1'b0);
    run0(0, "n25sat", 16'd25, 16'd65535, 1'b1);
    run0(1, "n25wrap", 16'd25, 16'd9489, 1'b1);

    // Streaming n=5 with a 3-cycle stall on the third beat.
    wait_ready(2);
    din[2] = 16'd5;
    iv[2]  = 1'b1;
    tick();
    iv[2]  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      g = 0;
      while (!ov[2] && g < 20) begin
        tick();
        g++;
      end
      chk("strm_val", {16'd0, dout[2]}, {16'd0, exp_beats[k]});
      chk("strm_last", {31'd0, olast[2]}, (k == 5) ? 32'd1 : 32'd0);
      if (k == 2) begin
        ordy[2] = 1'b0;
        held    = dout[2];
        repeat (3) begin
          tick();
          chk("strm_stall", {15'd0, ov[2], dout[2]}, {15'd1, held});
        end
        ordy[2] = 1'b1;
      end
      tick();
      chk("strm_gap", {31'd0, ov[2]}, 32'd0);
    end
    chk("strm_idle", {31'd0, ir[2]}, 32'd1);

    // Asynchronous reset in the middle of a long calculation.
    wait_ready(0);
    din[0] = 16'd20;
    iv[0]  = 1'b1;
    tick();
    iv[0]  = 1'b0;
    tick();
    #3;
    nrst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, ov[0]}, 32'd0);
    chk("arst_out", {14'd0, ir[0], oovf[0], dout[0]}, 32'd0);
    repeat (2) tick();
    chk("arst_hold", {29'd0, ov}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    run0(0, "n7", 16'd7, 16'd13, 1'b0);

    // Back-to-back: in_valid stays high across two requests.
    ordy[0] = 1'b1;
    wait_ready(0);
    din[0] = 16'd3;
    iv[0]  = 1'b1;
    tick();
    din[0] = 16'd4;
    chk("b2b_busy", {31'd0, ir[0]}, 32'd0);
    g = 0;
    while (!ov[0] && g < 20) begin
      tick();
      g++;
    end
    chk("b2b_first", {16'd0, dout[0]}, 32'd2);
    chk("b2b_noacc", {31'd0, ir[0]}, 32'd0);
    tick();
    chk("b2b_retired", {30'd0, ov[0], ir[0]}, 32'd1);
    tick();
    iv[0] = 1'b0;
    chk("b2b_accept", {31'd0, ir[0]}, 32'd0);
    g = 0;
    while (!ov[0] && g < 20) begin
      tick();
      g++;
    end
    chk("b2b_second", {16'd0, dout[0]}, 32'd3);
    tick();
    ordy[0] = 1'b0;
    chk("b2b_done", {31'd0, ov[0]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fib_stream

`default_nettype wire
